// File: rtl/clock_pkg.sv
// Shared types, calendar constants and field widths for the HH:MM:SS time-set path.
package clock_pkg;

   localparam int HOURS_PER_DAY = 24;
   localparam int MIN_PER_HOUR  = 60;
   localparam int SEC_PER_MIN   = 60;
   localparam int SEC_PER_DAY   = 86_400;
   localparam int SEC_PER_HOUR  = MIN_PER_HOUR * SEC_PER_MIN;

   localparam int HOUR_W    = 5;
   localparam int MIN_W     = 6;
   localparam int SEC_W     = 6;
   localparam int DAYSEC_W  = 17;

   // Set-mode states; COMMIT is internal and shows as RUN on set_state
   typedef enum logic [2:0] {
      RUN    = 3'd0,
      HOUR   = 3'd1,
      MIN    = 3'd2,
      SEC    = 3'd3,
      COMMIT = 3'd4
   } set_state_t;

   // Elapsed seconds since midnight, evaluated at full 17-bit width (max 86_399)
   function automatic logic [DAYSEC_W-1:0] hms_to_sec(input logic [HOUR_W-1:0] h,
                                                      input logic [MIN_W-1:0]  m,
                                                      input logic [SEC_W-1:0]  s);
      return DAYSEC_W'(h) * DAYSEC_W'(SEC_PER_HOUR)
           + DAYSEC_W'(m) * DAYSEC_W'(SEC_PER_MIN)
           + DAYSEC_W'(s);
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw active-low push-button -> 2-flop synchronizer -> debounced level -> one-cycle press pulse.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic press
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic            sync_p0;
   logic            sync_p1;
   logic            level_q;
   logic            level_d1;
   logic [DB_W-1:0] db_cnt;
   logic            pressed_sync;

   assign pressed_sync = ~sync_p1;

   // Two-flop synchronizer; idles at the released (high) level
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
      end else begin
         sync_p0 <= btn_n;
         sync_p1 <= sync_p0;
      end
   end

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES straight cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_q <= 1'b0;
         db_cnt  <= '0;
      end else if (pressed_sync == level_q) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
         level_q <= pressed_sync;
         db_cnt  <= '0;
      end else begin
         db_cnt <= db_cnt + DB_W'(1);
      end
   end

   // Registered pulse on the released->pressed edge of the accepted level only
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_d1 <= 1'b0;
         press    <= 1'b0;
      end else begin
         level_d1 <= level_q;
         press    <= level_q & ~level_d1;
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: MODE walks hour -> minute -> second -> commit, INC bumps the edited field.
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
   parameter int unsigned BLINK_HALF_CYCLES = 12_500_000,
   parameter int unsigned TIMEOUT_CYCLES    = 500_000_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                btn_mode_n,
   input  logic                btn_inc_n,
   input  logic [HOUR_W-1:0]   cur_hour,
   input  logic [MIN_W-1:0]    cur_min,
   input  logic [SEC_W-1:0]    cur_sec,
   output logic                hold,
   output logic                load,
   output logic [DAYSEC_W-1:0] load_seconds,
   output logic [5:0]          blank_mask,
   output logic [1:0]          set_state
);

   localparam int BLINK_W = $clog2(2 * BLINK_HALF_CYCLES);
   localparam int TMO_W   = $clog2(TIMEOUT_CYCLES);

   set_state_t          state_q, state_d;
   logic [HOUR_W-1:0]   sh_h_q, sh_h_d;
   logic [MIN_W-1:0]    sh_m_q, sh_m_d;
   logic [SEC_W-1:0]    sh_s_q, sh_s_d;
   logic [BLINK_W-1:0]  blink_cnt;
   logic [TMO_W-1:0]    tmo_cnt;
   logic [DAYSEC_W-1:0] load_sec_q;
   logic                mode_p;
   logic                inc_p;
   logic                in_set;
   logic                timed_out;
   logic                restart;
   logic                blanked;

   // Increment with wrap to zero at the field modulus; fields never carry into each other
   function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] modulus);
      return (v == modulus - 6'd1) ? 6'd0 : v + 6'd1;
   endfunction

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk   (clk),
      .reset (reset),
      .btn_n (btn_mode_n),
      .press (mode_p)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
      .clk   (clk),
      .reset (reset),
      .btn_n (btn_inc_n),
      .press (inc_p)
   );

   assign in_set    = (state_q == HOUR) || (state_q == MIN) || (state_q == SEC);
   assign timed_out = in_set && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
   assign restart   = (state_d != state_q) || mode_p || inc_p;

   // Next-state and shadow update; MODE outranks INC, and any press outranks the timeout
   always_comb begin
      state_d = state_q;
      sh_h_d  = sh_h_q;
      sh_m_d  = sh_m_q;
      sh_s_d  = sh_s_q;
      case (state_q)
         RUN: begin
            if (mode_p) begin
               state_d = HOUR;
               sh_h_d  = cur_hour;
               sh_m_d  = cur_min;
               sh_s_d  = cur_sec;
            end
         end
         HOUR: begin
            if (mode_p)         state_d = MIN;
            else if (inc_p)     sh_h_d  = HOUR_W'(wrap_inc(6'(sh_h_q), 6'(HOURS_PER_DAY)));
            else if (timed_out) state_d = RUN;
         end
         MIN: begin
            if (mode_p)         state_d = SEC;
            else if (inc_p)     sh_m_d  = wrap_inc(sh_m_q, 6'(MIN_PER_HOUR));
            else if (timed_out) state_d = RUN;
         end
         SEC: begin
            if (mode_p)         state_d = COMMIT;
            else if (inc_p)     sh_s_d  = wrap_inc(sh_s_q, 6'(SEC_PER_MIN));
            else if (timed_out) state_d = RUN;
         end
         COMMIT:  state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // State and shadow registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         sh_h_q  <= '0;
         sh_m_q  <= '0;
         sh_s_q  <= '0;
      end else begin
         state_q <= state_d;
         sh_h_q  <= sh_h_d;
         sh_m_q  <= sh_m_d;
         sh_s_q  <= sh_s_d;
      end
   end

   // Blink and idle-timeout counters; both restart on state entry and on any accepted press
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink_cnt <= '0;
         tmo_cnt   <= '0;
      end else if (restart || !in_set) begin
         blink_cnt <= '0;
         tmo_cnt   <= '0;
      end else begin
         blink_cnt <= (blink_cnt == BLINK_W'(2 * BLINK_HALF_CYCLES - 1)) ? '0 : blink_cnt + BLINK_W'(1);
         tmo_cnt   <= tmo_cnt + TMO_W'(1);
      end
   end

   // Load value is latched on the way into COMMIT and held until the next commit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_sec_q <= '0;
      end else if (state_q == SEC && state_d == COMMIT) begin
         load_sec_q <= hms_to_sec(sh_h_q, sh_m_q, sh_s_q);
      end
   end

   assign blanked = in_set && (blink_cnt >= BLINK_W'(BLINK_HALF_CYCLES));

   // Output decode from registered state so reset clears everything immediately
   always_comb begin
      hold         = (state_q != RUN);
      load         = (state_q == COMMIT);
      load_seconds = load_sec_q;
      set_state    = (state_q == COMMIT) ? 2'd0 : state_q[1:0];
      blank_mask   = 6'b000000;
      if (blanked) begin
         case (state_q)
            HOUR:    blank_mask = 6'b110000;
            MIN:     blank_mask = 6'b001100;
            SEC:     blank_mask = 6'b000011;
            default: blank_mask = 6'b000000;
         endcase
      end
   end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Time-set controller for the 24-hour HH:MM:SS display clock.
- Takes two raw push-buttons (MODE, INC) and walks the user through editing hours, then minutes, then seconds.
- Freezes the seconds counter while editing and blinks the digit pair being edited.
- On commit, issues a one-cycle load of the new elapsed-seconds value (0..86_399) into the time counter.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronized cycles before a button level is accepted (20 ms @ 50 MHz).
- BLINK_HALF_CYCLES, 12_500_000, length of each blink phase (visible / blanked).
- TIMEOUT_CYCLES, 500_000_000, idle cycles in a set state before aborting without load (10 s).

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- btn_mode_n  in  1  raw MODE button, active-low, asynchronous to clk
- btn_inc_n  in  1  raw INC button, active-low, asynchronous to clk
- cur_hour  in  5  live hour from the time counter, 0..23
- cur_min  in  6  live minute, 0..59
- cur_sec  in  6  live second, 0..59
- hold  out  1  high: time counter must not advance
- load  out  1  one-cycle pulse: time counter takes load_seconds
- load_seconds  out  17  hour*3600 + min*60 + sec of the edited time
- blank_mask  out  6  per-digit blank; bit0/1 = seconds ones/tens, bits 2/3 = minutes, bits 4/5 = hours
- set_state  out  2  0 RUN, 1 HOUR, 2 MIN, 3 SEC (debug/LED)

Behaviour:
- Reset asserted (reset=0), any time including mid-edit: immediately state RUN, hold=0, load=0, load_seconds=0, blank_mask=0, shadow registers 0, debounce and timers cleared, accepted button levels = released.
- Button path, per button:
  - 2-flop synchronizer, then debounce counter.
  - The accepted level changes once the synced value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - A press pulse (1 cycle, registered) fires on the released->pressed transition only; release produces no pulse.
  - No auto-repeat.
- States: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT (COMMIT is internal; set_state reads 0 in it).
- RUN:
  - hold=0, blank_mask=0.
  - MODE press -> capture cur_hour/min/sec into shadow regs, go SET_HOUR. INC ignored.
- SET_HOUR / SET_MIN / SET_SEC:
  - hold=1.
  - INC press increments the selected shadow field with wrap: hour 23->0, minute 59->0, second 59->0. There is no carry between fields.
  - MODE press advances HOUR->MIN->SEC->COMMIT.
  - If MODE and INC press pulses occur in the same cycle, MODE wins and INC is discarded.
  - The shadow update or state change takes effect on the clock edge after the pulse cycle.
- Blink:
  - Counter restarts at 0 on every state entry and on every accepted press.
  - Phase visible for BLINK_HALF_CYCLES, then blanked for BLINK_HALF_CYCLES, repeating.
  - During the blanked phase, blank_mask = 6'b110000 / 6'b001100 / 6'b000011 for HOUR / MIN / SEC. Otherwise 0.
- Timeout:
  - Counter restarts on state entry and on any accepted press.
  - Reaching TIMEOUT_CYCLES-1 in a set state -> RUN with no load; shadow is discarded.
- COMMIT, exactly one cycle:
  - load=1, hold=1, load_seconds = shadow_h*3600 + shadow_m*60 + shadow_s.
  - The sum is computed at 17-bit width; the maximum is 86_399.
  - load_seconds is registered and stays stable until the next COMMIT.
  - Next state is RUN.
- Total latency from raw MODE edge (clean) to state change: 2 sync + DEBOUNCE_CYCLES + 1 pulse register + 1 cycles.

Decomposition:
- Shared package clock_pkg holds:
  - set_state_t enum (RUN=0, HOUR=1, MIN=2, SEC=3, plus COMMIT).
  - Constants HOURS_PER_DAY=24, MIN_PER_HOUR=60, SEC_PER_MIN=60, SEC_PER_DAY=86_400.
  - Field widths 5/6/6/17.
- One sub-module, button_debounce (sync + debounce + press pulse, parameter DEBOUNCE_CYCLES), instantiated for MODE and INC.
- Controller FSM, blink/timeout counters and load arithmetic stay in clock_set_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_HALF_CYCLES=8, TIMEOUT_CYCLES=64):
- Bounce MODE 0/1/0 at 1-2 cycle spacing, then hold low 10 cycles -> exactly one press; set_state 0->1; shadow = cur time 13:45:30; hold=1.
- In HOUR with shadow hour 23: one INC -> hour 0. Three MODE presses -> one-cycle load with load_seconds = 0*3600 + 45*60 + 30 = 2_730; then RUN, hold=0.
- Minute 59 plus INC -> 0; second 59 plus INC -> 0; hour unchanged (no carry). Commit from 05:59:59 with those two INCs -> load_seconds = 18_000.
- In SET_MIN, observe blank_mask: 0 for 8 cycles, 6'b001100 for 8 cycles, repeating. An INC press restarts the phase at visible.
- Enter SET_SEC, no presses for 64 cycles -> RUN; load never pulses; load_seconds keeps its previous value.
- MODE and INC pulses in the same cycle in SET_HOUR -> advance to MIN with hour unchanged. Assert reset mid-SET_SEC -> same-cycle outputs 0 and set_state=0.
